fifo_arb_ctrl: RTL and testbench

Controller that sequences the team's `fifo_mem` storage block and shares its write port between two producers. It round-robin arbitrates two write requesters, tracks occupancy, and drives the memory's write enable, read enable and reset. It presents a one-entry valid/ready read interface built on the memory's registered read. It sits directly between the producers, `fifo_mem`, and the downstream consumer.

---
 rtl/fifo_arb_ctrl.sv | 104 ++++++++++
 tb/tb_fifo_arb_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_arb_ctrl.sv
// fifo_arb_ctrl: two-producer round-robin write arbiter and occupancy tracker
// sequencing an external fifo_mem. It also provides a one-entry valid/ready
// read stage on top of the memory's registered read port.
module fifo_arb_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DATA_DEPTH = 16,
    parameter int unsigned UP_BIT     = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rest,
    input  logic                  i_flush,
    input  logic                  i_wr_req0,
    input  logic                  i_wr_req1,
    input  logic [DATA_WIDTH-1:0] i_wr_data0,
    input  logic [DATA_WIDTH-1:0] i_wr_data1,
    output logic                  o_wr_gnt0,
    output logic                  o_wr_gnt1,
    output logic                  o_rd_valid,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    input  logic                  i_rd_ready,
    output logic                  o_mem_wen,
    output logic                  o_mem_ren,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    output logic                  o_mem_rst,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    output logic [UP_BIT:0]       o_count,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int unsigned CNT_W = UP_BIT + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DATA_DEPTH);

    logic [CNT_W-1:0]      r_cnt;
    logic                  r_out_vld;
    logic                  r_prio;

    logic                  w_block;
    logic                  w_full;
    logic                  w_gnt0;
    logic                  w_gnt1;
    logic                  w_wen;
    logic                  w_ren;
    logic [DATA_WIDTH-1:0] w_wdata;

    assign w_block = i_flush | i_rest;
    assign w_full  = (r_cnt == DEPTH_C);

    // Round-robin write arbitration; blocked while full, flushing or in reset
    always_comb begin
        w_gnt0  = 1'b0;
        w_gnt1  = 1'b0;
        w_wdata = '0;
        if (!w_block && !w_full) begin
            case ({i_wr_req1, i_wr_req0})
                2'b01:   w_gnt0 = 1'b1;
                2'b10:   w_gnt1 = 1'b1;
                2'b11: begin
                    if (r_prio) w_gnt1 = 1'b1;
                    else        w_gnt0 = 1'b1;
                end
                default: ;
            endcase
        end
        if (w_gnt0)      w_wdata = i_wr_data0;
        else if (w_gnt1) w_wdata = i_wr_data1;
    end

    assign w_wen = w_gnt0 | w_gnt1;
    // Read only from a non-empty memory when the output stage is free or draining
    assign w_ren = !w_block && (r_cnt != '0) && (!r_out_vld || i_rd_ready);

    // Occupancy, output-stage valid and arbitration priority
    always_ff @(posedge i_clk or posedge i_rest) begin
        if (i_rest) begin
            r_cnt     <= '0;
            r_out_vld <= 1'b0;
            r_prio    <= 1'b0;
        end else if (i_flush) begin
            r_cnt     <= '0;
            r_out_vld <= 1'b0;
            r_prio    <= 1'b0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(w_wen) - CNT_W'(w_ren);
            if (w_ren)           r_out_vld <= 1'b1;
            else if (i_rd_ready) r_out_vld <= 1'b0;
            if (w_gnt0)      r_prio <= 1'b1;
            else if (w_gnt1) r_prio <= 1'b0;
        end
    end

    assign o_wr_gnt0   = w_gnt0;
    assign o_wr_gnt1   = w_gnt1;
    assign o_mem_wen   = w_wen;
    assign o_mem_ren   = w_ren;
    assign o_mem_wdata = w_wdata;
    assign o_mem_rst   = i_rest | i_flush;
    assign o_rd_valid  = r_out_vld;
    assign o_rd_data   = i_mem_rdata;
    assign o_count     = r_cnt;
    assign o_full      = w_full;
    assign o_empty     = (r_cnt == '0) && !r_out_vld;

endmodule

// File: tb/tb_fifo_arb_ctrl.sv
// Bench for fifo_arb_ctrl: a simple fifo_mem stand-in, queue-based reference
// model, directed scenarios and a randomized phase.
module tb_fifo_arb_ctrl;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned UB    = 4;

    logic          i_clk = 1'b0;
    logic          i_rest, i_flush;
    logic          i_wr_req0, i_wr_req1;
    logic [DW-1:0] i_wr_data0, i_wr_data1;
    logic          o_wr_gnt0, o_wr_gnt1;
    logic          o_rd_valid;
    logic [DW-1:0] o_rd_data;
    logic          i_rd_ready;
    logic          o_mem_wen, o_mem_ren;
    logic [DW-1:0] o_mem_wdata;
    logic          o_mem_rst;
    logic [DW-1:0] i_mem_rdata;
    logic [UB:0]   o_count;
    logic          o_full, o_empty;

    fifo_arb_ctrl #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .UP_BIT(UB)) dut (
        .i_clk(i_clk), .i_rest(i_rest), .i_flush(i_flush),
        .i_wr_req0(i_wr_req0), .i_wr_req1(i_wr_req1),
        .i_wr_data0(i_wr_data0), .i_wr_data1(i_wr_data1),
        .o_wr_gnt0(o_wr_gnt0), .o_wr_gnt1(o_wr_gnt1),
        .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data), .i_rd_ready(i_rd_ready),
        .o_mem_wen(o_mem_wen), .o_mem_ren(o_mem_ren), .o_mem_wdata(o_mem_wdata),
        .o_mem_rst(o_mem_rst), .i_mem_rdata(i_mem_rdata),
        .o_count(o_count), .o_full(o_full), .o_empty(o_empty)
    );

    always #5 i_clk = ~i_clk;

    // fifo_mem stand-in: pointer-based storage with registered read
    logic [DW-1:0] mem [DEPTH];
    logic [UB-1:0] mem_wp, mem_rp;
    logic [DW-1:0] mem_rd;
    always @(posedge i_clk) begin
        if (o_mem_rst) begin
            mem_wp <= '0;
            mem_rp <= '0;
            mem_rd <= '0;
        end else begin
            if (o_mem_wen) begin
                mem[mem_wp] <= o_mem_wdata;
                mem_wp      <= UB'(mem_wp + 1);
            end
            if (o_mem_ren) begin
                mem_rd <= mem[mem_rp];
                mem_rp <= UB'(mem_rp + 1);
            end
        end
    end
    assign i_mem_rdata = mem_rd;

    int n_err = 0;
    int n_chk = 0;

    // Reference model: words in memory as a queue, plus the output stage
    logic [DW-1:0] m_q [$];
    logic          m_ov;
    logic [DW-1:0] m_word;
    logic          m_prio;

    // Producer backlogs and accepted output words
    logic [DW-1:0] p0 [$];
    logic [DW-1:0] p1 [$];
    logic [DW-1:0] outs [$];

    logic rdy, fl;
    logic s_g0, s_g1, s_ren, s_mrst, s_valid, s_full, s_empty;
    logic [UB:0]   s_count;
    logic [DW-1:0] s_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ov   = 1'b0;
        m_word = '0;
        m_prio = 1'b0;
    endtask

    // One clock cycle: drive, compare against the model at negedge, commit
    task automatic cycle();
        logic e_g0, e_g1, e_ren, full, r0, r1;
        logic [DW-1:0] d0, d1, e_wd;
        r0 = (p0.size() > 0);
        r1 = (p1.size() > 0);
        d0 = r0 ? p0[0] : DW'($urandom);
        d1 = r1 ? p1[0] : DW'($urandom);
        i_wr_req0 = r0; i_wr_data0 = d0;
        i_wr_req1 = r1; i_wr_data1 = d1;
        i_rd_ready = rdy;
        i_flush = fl;
        @(negedge i_clk);
        full  = (m_q.size() == DEPTH);
        e_g0  = !fl && !full && r0 && (!r1 || !m_prio);
        e_g1  = !fl && !full && r1 && (!r0 || m_prio);
        e_wd  = e_g0 ? d0 : (e_g1 ? d1 : '0);
        e_ren = !fl && (m_q.size() != 0) && (!m_ov || rdy);
        chk("gnt0", 32'(o_wr_gnt0), 32'(e_g0));
        chk("gnt1", 32'(o_wr_gnt1), 32'(e_g1));
        chk("mem_wen", 32'(o_mem_wen), 32'(e_g0 | e_g1));
        chk("mem_wdata", 32'(o_mem_wdata), 32'(e_wd));
        chk("mem_ren", 32'(o_mem_ren), 32'(e_ren));
        chk("mem_rst", 32'(o_mem_rst), 32'(fl));
        chk("count", 32'(o_count), 32'(m_q.size()));
        chk("full", 32'(o_full), 32'(full));
        chk("empty", 32'(o_empty), 32'((m_q.size() == 0) && !m_ov));
        chk("rd_valid", 32'(o_rd_valid), 32'(m_ov));
        if (m_ov) chk("rd_data", 32'(o_rd_data), 32'(m_word));
        s_g0 = o_wr_gnt0; s_g1 = o_wr_gnt1; s_ren = o_mem_ren; s_mrst = o_mem_rst;
        s_valid = o_rd_valid; s_data = o_rd_data; s_count = o_count;
        s_full = o_full; s_empty = o_empty;
        if (o_rd_valid && rdy && !fl) outs.push_back(o_rd_data);
        @(posedge i_clk);
        #1;
        if (fl) begin
            model_reset();
        end else begin
            if (e_ren) begin
                m_word = m_q.pop_front();
                m_ov   = 1'b1;
            end else if (rdy) begin
                m_ov = 1'b0;
            end
            if (e_g0) begin
                m_q.push_back(d0);
                void'(p0.pop_front());
                m_prio = 1'b1;
            end else if (e_g1) begin
                m_q.push_back(d1);
                void'(p1.pop_front());
                m_prio = 1'b0;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_count"}, 32'(o_count), 0);
        chk({tag, "_full"}, 32'(o_full), 0);
        chk({tag, "_empty"}, 32'(o_empty), 1);
        chk({tag, "_valid"}, 32'(o_rd_valid), 0);
        chk({tag, "_gnt"}, 32'({o_wr_gnt1, o_wr_gnt0}), 0);
        chk({tag, "_wen"}, 32'(o_mem_wen), 0);
        chk({tag, "_ren"}, 32'(o_mem_ren), 0);
        chk({tag, "_mrst"}, 32'(o_mem_rst), 1);
    endtask

    task automatic chk_outs(input string tag, input logic [DW-1:0] exp [$]);
        chk({tag, "_len"}, 32'(outs.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < outs.size(); i++)
            chk({tag, "_word"}, 32'(outs[i]), 32'(exp[i]));
    endtask

    initial begin
        logic [DW-1:0] exp [$];
        i_rest = 1'b1; i_flush = 1'b0; i_rd_ready = 1'b0;
        i_wr_req0 = 1'b1; i_wr_req1 = 1'b1; i_wr_data0 = '0; i_wr_data1 = '0;
        rdy = 1'b0; fl = 1'b0;
        model_reset();
        @(negedge i_clk);
        chk_reset_outputs("reset");
        @(posedge i_clk); #1;
        i_rest = 1'b0;

        // Three words from producer 0, consumer always ready
        rdy = 1'b1;
        p0 = '{8'h11, 8'h22, 8'h33};
        cycle(); chk("t1_first_gnt", 32'(s_g0), 1);
        chk("t1_valid_t", 32'(s_valid), 0);
        cycle(); chk("t1_valid_t1", 32'(s_valid), 0);
        cycle(); chk("t1_valid_t2", 32'(s_valid), 1); chk("t1_data_t2", 32'(s_data), 32'h11);
        cycle(); chk("t1_data_t3", 32'(s_data), 32'h22);
        cycle(); chk("t1_data_t4", 32'(s_data), 32'h33);
        cycle(); chk("t1_empty_after", 32'(s_empty), 1);

        // Both producers contending, starting from cleared priority
        fl = 1'b1; cycle(); fl = 1'b0;
        outs.delete();
        for (int i = 0; i < 4; i++) begin
            p0.push_back(DW'(8'hA0 + i));
            p1.push_back(DW'(8'hB0 + i));
        end
        cycle(); chk("t2_first_g0", 32'(s_g0), 1); chk("t2_first_g1", 32'(s_g1), 0);
        cycle(); chk("t2_second_g1", 32'(s_g1), 1);
        run(10);
        exp = '{8'hA0, 8'hB0, 8'hA1, 8'hB1, 8'hA2, 8'hB2, 8'hA3, 8'hB3};
        chk_outs("t2_order", exp);

        // Fill to full capacity with backpressure, then pulse ready at full
        outs.delete();
        rdy = 1'b0;
        for (int i = 0; i < 17; i++) p0.push_back(DW'(8'h40 + i));
        run(20);
        chk("t3_count16", 32'(s_count), 16);
        chk("t3_full", 32'(s_full), 1);
        chk("t3_valid", 32'(s_valid), 1);
        chk("t3_held_word", 32'(s_data), 32'h40);
        p0.push_back(8'h51);
        cycle(); chk("t3_18th_nogrant", 32'(s_g0), 0);
        cycle(); chk("t3_18th_nogrant2", 32'(s_g0), 0);
        rdy = 1'b1;
        cycle(); chk("t4_pulse_nogrant", 32'(s_g0), 0); chk("t4_pulse_ren", 32'(s_ren), 1);
        rdy = 1'b0;
        cycle(); chk("t4_count_after_read", 32'(s_count), 15); chk("t4_grant_next", 32'(s_g0), 1);
        chk("t4_next_word", 32'(s_data), 32'h41);
        cycle(); chk("t4_count_refull", 32'(s_count), 16);
        rdy = 1'b1;
        run(22);
        exp.delete();
        for (int i = 0; i < 17; i++) exp.push_back(DW'(8'h40 + i));
        exp.push_back(8'h51);
        chk_outs("t3_drain", exp);

        // Flush with five words stored
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) p0.push_back(DW'(8'h70 + i));
        run(7);
        fl = 1'b1;
        cycle(); chk("t5_mem_rst", 32'(s_mrst), 1); chk("t5_flush_ren", 32'(s_ren), 0);
        fl = 1'b0;
        cycle(); chk("t5_count0", 32'(s_count), 0); chk("t5_valid0", 32'(s_valid), 0);
        chk("t5_empty", 32'(s_empty), 1);
        outs.delete();
        rdy = 1'b1;
        p0.push_back(8'h5A);
        run(4);
        exp = '{8'h5A};
        chk_outs("t5_after_flush", exp);

        // Asynchronous reset in the middle of a stream
        for (int i = 0; i < 6; i++) p0.push_back(DW'(8'h90 + i));
        run(4);
        #2;
        i_rest = 1'b1;
        #1;
        chk_reset_outputs("async");
        p0.delete(); p1.delete(); outs.delete();
        model_reset();
        i_wr_req0 = 1'b0; i_wr_req1 = 1'b0;
        @(posedge i_clk); #1;
        i_rest = 1'b0;
        p1 = '{8'hC1, 8'hC2};
        run(6);
        exp = '{8'hC1, 8'hC2};
        chk_outs("async_resume", exp);

        // Randomized traffic with phases of heavy backpressure and rare flushes
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 2) == 0 && p0.size() < 3) p0.push_back(DW'($urandom));
            if ($urandom_range(0, 2) == 0 && p1.size() < 3) p1.push_back(DW'($urandom));
            if ((i / 150) % 2 == 1) rdy = ($urandom_range(0, 7) == 0);
            else                    rdy = ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 199) == 0);
            if (fl) rdy = 1'b0;
            cycle();
        end
        fl = 1'b0; rdy = 1'b1;
        run(40);
        chk("final_empty", 32'(s_empty), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
